filter_fetch_stream: RTL and testbench
======================================

// Module: filter_fetch_stream
// PURPOSE
// - Reads one filter's weights from the packed 4-bytes-per-word filter memory.
// - Generates byte addresses for the memory and latches each 32-bit word.
// - Emits the weights as a byte stream with valid/ready handshake to the PE/MAC stage.
// - Sits between the filter memory (upstream) and the convolution datapath (downstream).
// PARAMETERS
// - CAPACITY      16  filter memory depth in 32-bit words
// - NO_BITS       8   byte-address width shared with the filter memory
// - FILTER_BYTES  16  weights per filter; 1..4*CAPACITY, need not be a multiple of 4
// PORTS
// - clk        in   1        rising-edge clock
// - rst        in   1        asynchronous, active-low reset
// - start      in   1        request one filter fetch; sampled only in IDLE
// - base_addr  in   NO_BITS  byte address of the filter's first weight; bits[1:0] ignored (forced 0)
// - mem_addr   out  NO_BITS  byte address to filter memory (word = mem_addr>>2)
// - mem_data   in   8 x4     memory word; [0] = bits 31:24 = first byte, [3] = bits 7:0 = last byte
// - mem_done   out  1        drives memory's done input; 1 in IDLE, 0 while busy
// - data_out   out  8        current weight byte
// - valid      out  1        data_out valid
// - ready      in   1        downstream accepts on valid&&ready
// - last       out  1        with valid: final byte of the filter
// - busy       out  1        fetch in progress (state != IDLE)
// - done       out  1        one-cycle pulse after last byte is accepted
// BEHAVIOUR
// - Reset (rst=0, any time, mid-fetch included): state=IDLE, mem_addr=0, data_out=0,
//   valid=0, last=0, busy=0, done=0, mem_done=1; byte/word counters=0.
//   Output is held until rst deasserts.
// - FSM states: IDLE, FETCH, EMIT, FIN.
//   IDLE : start=1 -> latch base_addr&~3 into mem_addr, byte_cnt=0, go FETCH.
//   FETCH: memory read is combinational. Capture mem_data[0..3] into word_buf
//          at this edge, byte_sel=0, go EMIT. Exactly one cycle.
//   EMIT : valid=1, data_out=word_buf[byte_sel], last=(byte_cnt==FILTER_BYTES-1).
//          On valid&&ready: byte_cnt++, byte_sel++.
//          - If last: go FIN.
//          - Else if byte_sel==3: mem_addr+=4, go FETCH.
//          - Else: stay in EMIT.
//          No handshake: data_out/last/valid held stable.
//   FIN  : done=1 for exactly one cycle, busy=0 next, go IDLE.
// - Latency: start -> first valid = 2 cycles. Full rate: 4 bytes per 5 cycles.
// - Partial last word: only FILTER_BYTES mod 4 bytes emitted. Remaining bytes of
//   that word are never presented.
// - mem_addr arithmetic is modulo 2^NO_BITS: 0xFC+4 wraps to 0x00, no error.
// - start while busy is ignored, not queued.
// - start asserted in the FIN cycle is also ignored. It is accepted only once
//   back in IDLE.
// - ready may toggle freely; there is no combinational path from ready to valid
//   or data_out.
// CONFIGURATION
// - FILTER_FETCH_CHKSUM_EN defined:
//   - Adds output port chksum[15:0].
//   - chksum clears to 0 on reset and on start acceptance.
//   - It adds the zero-extended data_out on every handshake.
//   - Value is stable from the done pulse until the next start.
// - Not defined: port and adder absent; all other behaviour identical.
// TESTING
// - Reset mid-EMIT (after 3 bytes accepted) -> next cycle valid=0, busy=0,
//   mem_addr=0, mem_done=1. A new start refetches from byte 0.
// - Memory words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10; base=0;
//   ready=1 -> bytes 01..10 in order, last with 0x10, done pulse one cycle later.
//   Total 21 cycles from start to done.
// - FILTER_BYTES=6, same memory -> bytes 01..06 emitted, last on 06.
//   Only 2 FETCH cycles (addr 0x00, 0x04).
// - ready held 0 for 5 cycles at byte 3 -> data_out=0x03 and valid stable
//   throughout; exactly one transfer when ready=1.
// - NO_BITS=4, base_addr=0xC, FILTER_BYTES=8 -> mem_addr sequence 0xC, 0x0.
//   start pulsed while busy has no effect.
// - FILTER_FETCH_CHKSUM_EN with the 16-byte test -> chksum=0x0088 at done.

Source files
------------

// File: rtl/filter_fetch_stream.sv
// filter_fetch_stream
// Reads one filter's weights from a packed 4-bytes-per-word filter memory and
// streams them out one byte at a time with a valid/ready handshake.
// Optional feature macro: FILTER_FETCH_CHKSUM_EN adds a 16-bit running byte sum
// on output port chksum.
module filter_fetch_stream #(
  parameter int CAPACITY     = 16,  // filter memory depth in 32-bit words
  parameter int NO_BITS      = 8,   // byte-address width
  parameter int FILTER_BYTES = 16   // weights per filter, 1..4*CAPACITY
) (
  input  logic               clk,
  input  logic               rst,        // asynchronous, active low
  input  logic               start,
  input  logic [NO_BITS-1:0] base_addr,
  output logic [NO_BITS-1:0] mem_addr,
  input  logic [0:3][7:0]    mem_data,   // [0] = bits 31:24 = first byte
  output logic               mem_done,
  output logic [7:0]         data_out,
  output logic               valid,
  input  logic               ready,
  output logic               last,
  output logic               busy,
`ifdef FILTER_FETCH_CHKSUM_EN
  output logic [15:0]        chksum,
`endif
  output logic               done
);

  // Byte counter must be able to reach FILTER_BYTES on the final handshake.
  localparam int                 CNT_W      = $clog2(4 * CAPACITY + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(FILTER_BYTES - 1);
  localparam logic [NO_BITS-1:0] ALIGN_MASK = ~NO_BITS'(3);
  localparam logic [NO_BITS-1:0] WORD_STEP  = NO_BITS'(4);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FIN} state_t;

  state_t             state, state_next;
  logic [0:3][7:0]    word_buf;
  logic [1:0]         byte_sel;
  logic [CNT_W-1:0]   byte_cnt;
  logic               last_byte;
  logic               xfer;

  // Outputs decode registered state only, so ready never reaches valid/data_out.
  assign valid     = (state == EMIT);
  assign last_byte = (byte_cnt == LAST_IDX);
  assign last      = valid && last_byte;
  assign xfer      = valid && ready;
  assign busy      = (state != IDLE);
  assign mem_done  = !busy;
  assign done      = (state == FIN);
  assign data_out  = word_buf[byte_sel];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state decode: one FETCH per word, EMIT until the word or filter ends.
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: state_next = EMIT;
      EMIT: begin
        if (xfer) begin
          if (last_byte)            state_next = FIN;
          else if (byte_sel == 2'd3) state_next = FETCH;
        end
      end
      FIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address generation, word capture and byte counting.
  // NOTE: word_buf is a four-byte register, not a memory, so it is reset;
  // that also gives data_out its defined zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      word_buf <= '0;
      byte_sel <= '0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_addr <= base_addr & ALIGN_MASK;
            byte_cnt <= '0;
          end
        end
        FETCH: begin
          word_buf <= mem_data;
          byte_sel <= '0;
        end
        EMIT: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 1'b1;
            byte_sel <= byte_sel + 2'd1;
            // Address wraps modulo 2^NO_BITS by design.
            if (!last_byte && byte_sel == 2'd3) mem_addr <= mem_addr + WORD_STEP;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FILTER_FETCH_CHKSUM_EN
  // Running sum of accepted bytes; cleared when a fetch is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        chksum <= '0;
    else if (state == IDLE && start) chksum <= '0;
    else if (xfer)                   chksum <= chksum + 16'(data_out);
  end
`endif

endmodule

// File: tb/tb_filter_fetch_stream.sv
// Self-checking bench for filter_fetch_stream. Instance a (16 bytes, 8-bit
// addresses) is tracked every cycle by a queue-based stream model; instances
// b (6 bytes) and c (4-bit addresses, 8 bytes) get directed checks.
module tb_filter_fetch_stream;

  localparam int FB_A = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] mem [64];

  // Instance a
  logic            start_a, ready_a;
  logic [7:0]      base_a, mem_addr_a, data_out_a;
  logic [0:3][7:0] mem_data_a;
  logic            mem_done_a, valid_a, last_a, busy_a, done_a;
  // Instance b
  logic            start_b, ready_b;
  logic [7:0]      base_b, mem_addr_b, data_out_b;
  logic [0:3][7:0] mem_data_b;
  logic            mem_done_b, valid_b, last_b, busy_b, done_b;
  // Instance c
  logic            start_c, ready_c;
  logic [3:0]      base_c, mem_addr_c;
  logic [7:0]      data_out_c;
  logic [0:3][7:0] mem_data_c;
  logic            mem_done_c, valid_c, last_c, busy_c, done_c;
`ifdef FILTER_FETCH_CHKSUM_EN
  logic [15:0]     chksum_a, chksum_b, chksum_c;
`endif

  assign mem_data_a = mem[mem_addr_a[7:2]];
  assign mem_data_b = mem[mem_addr_b[7:2]];
  assign mem_data_c = mem[mem_addr_c[3:2]];

  filter_fetch_stream #(.CAPACITY(16), .NO_BITS(8), .FILTER_BYTES(FB_A)) dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .base_addr(base_a), .mem_addr(mem_addr_a),
    .mem_data(mem_data_a), .mem_done(mem_done_a), .data_out(data_out_a), .valid(valid_a),
    .ready(ready_a), .last(last_a), .busy(busy_a),
`ifdef FILTER_FETCH_CHKSUM_EN
    .chksum(chksum_a),
`endif
    .done(done_a));

  filter_fetch_stream #(.CAPACITY(16), .NO_BITS(8), .FILTER_BYTES(6)) dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .base_addr(base_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .mem_done(mem_done_b), .data_out(data_out_b), .valid(valid_b),
    .ready(ready_b), .last(last_b), .busy(busy_b),
`ifdef FILTER_FETCH_CHKSUM_EN
    .chksum(chksum_b),
`endif
    .done(done_b));

  filter_fetch_stream #(.CAPACITY(4), .NO_BITS(4), .FILTER_BYTES(8)) dut_c (
    .clk(clk), .rst(rst_n), .start(start_c), .base_addr(base_c), .mem_addr(mem_addr_c),
    .mem_data(mem_data_c), .mem_done(mem_done_c), .data_out(data_out_c), .valid(valid_c),
    .ready(ready_c), .last(last_c), .busy(busy_c),
`ifdef FILTER_FETCH_CHKSUM_EN
    .chksum(chksum_c),
`endif
    .done(done_c));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte i of a filter starting at base: consecutive byte addresses from the
  // word-aligned base, wrapping at 256, big-endian within each word.
  function automatic logic [7:0] ref_byte(input logic [7:0] base, input int idx);
    logic [7:0]  addr;
    logic [31:0] w;
    int          sh;
    addr = (base & 8'hFC) + 8'(idx);
    w    = mem[addr[7:2]];
    sh   = 24 - 8 * int'(addr[1:0]);
    return w[sh +: 8];
  endfunction

  // ---------------------------------------------------------------------
  // Stream model for instance a, compared every falling edge.
  // ---------------------------------------------------------------------
  logic [7:0] q[$];
  bit         m_busy, done_due;
  int         gap, sent;
  logic [15:0] m_sum;

  initial begin
    m_busy = 0; done_due = 0; gap = 0; sent = 0; m_sum = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete(); m_busy = 0; done_due = 0; gap = 0; sent = 0; m_sum = '0;
      end else begin
        check("m_busy", busy_a, m_busy);
        check("m_mem_done", mem_done_a, !m_busy);
        check("m_done", done_a, done_due);
        if (done_due) begin
          check("m_valid_fin", valid_a, 0);
`ifdef FILTER_FETCH_CHKSUM_EN
          check("m_chksum", chksum_a, m_sum);
`endif
          m_busy = 0; done_due = 0;
        end else if (m_busy) begin
          if (gap > 0) begin
            check("m_valid_gap", valid_a, 0);
            gap--;
          end else if (q.size() > 0) begin
            check("m_valid", valid_a, 1);
            check("m_data", data_out_a, q[0]);
            check("m_last", last_a, q.size() == 1);
            if (ready_a) begin
              m_sum = m_sum + 16'(q[0]);
              void'(q.pop_front());
              sent++;
              if (q.size() == 0)     done_due = 1;
              else if (sent % 4 == 0) gap = 1;
            end
          end
        end else begin
          check("m_valid_idle", valid_a, 0);
          check("m_last_idle", last_a, 0);
          if (start_a) begin
            for (int i = 0; i < FB_A; i++) q.push_back(ref_byte(base_a, i));
            m_busy = 1; gap = 1; sent = 0; m_sum = '0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a && n < 200) begin tick(); n++; end
    check("idle_timeout_a", busy_a, 0);
  endtask

  logic [7:0] got[$];
  logic [7:0] addrs[$];
  int busy_cnt, last_idx, fin_seen;
  bit found;
  logic [7:0] exp_c [8];

  initial begin
    mem[0] = 32'h01020304; mem[1] = 32'h05060708;
    mem[2] = 32'h090A0B0C; mem[3] = 32'h0D0E0F10;
    for (int i = 4; i < 64; i++) mem[i] = $urandom;
    exp_c = '{8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
    start_a = 0; ready_a = 0; base_a = '0;
    start_b = 0; ready_b = 1; base_b = '0;
    start_c = 0; ready_c = 1; base_c = '0;
    rst_n = 0;
    repeat (3) tick();

    // Reset state
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_mem_done", mem_done_a, 1);
    check("rst_mem_addr", mem_addr_a, 0);
    check("rst_data_out", data_out_a, 0);
    check("rst_last", last_a, 0);
    check("rst_done", done_a, 0);
    rst_n = 1;
    tick();

    // Pin the reference function with hand-computed bytes.
    check("model_b0", ref_byte(8'h00, 0), 8'h01);
    check("model_b15", ref_byte(8'h00, 15), 8'h10);
    check("model_wrap", ref_byte(8'hFD, 4), 8'h01);

    // 16-byte fetch at full rate, plus a start raised during FIN.
    ready_a = 1; base_a = 8'h00; start_a = 1;
    tick();
    start_a = 0;
    got.delete(); busy_cnt = 0; last_idx = -1; fin_seen = 0;
    for (int i = 0; i < 60 && !fin_seen; i++) begin
      if (busy_a) busy_cnt++;
      if (valid_a && ready_a) begin
        if (last_a) last_idx = got.size();
        got.push_back(data_out_a);
      end
      if (done_a) begin
        fin_seen = 1; start_a = 1; base_a = 8'h10;
      end else tick();
    end
    tick();
    start_a = 0;
    check("t1_done_seen", fin_seen, 1);
    check("t1_busy_cycles", busy_cnt, 21);
    check("t1_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) check("t1_byte", got[i], 8'(i + 1));
    check("t1_last_idx", last_idx, 15);
    check("fin_start_ignored", busy_a, 0);
    tick();
    check("fin_start_still_idle", busy_a, 0);
`ifdef FILTER_FETCH_CHKSUM_EN
    check("t1_chksum", chksum_a, 16'h0088);
`endif

    // Stall with ready low for 5 cycles while byte 0x03 is presented.
    base_a = 8'h00; start_a = 1;
    tick();
    start_a = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid_a && data_out_a == 8'h03) found = 1; else tick();
    end
    check("stall_found", found, 1);
    ready_a = 0;
    repeat (5) begin
      tick();
      check("stall_valid", valid_a, 1);
      check("stall_data", data_out_a, 8'h03);
    end
    ready_a = 1;
    tick();
    check("stall_one_xfer", data_out_a, 8'h04);
    wait_idle_a();

    // Reset after three bytes accepted, then refetch from byte 0.
    base_a = 8'h00; start_a = 1;
    tick();
    start_a = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (valid_a && data_out_a == 8'h04) found = 1; else tick();
    end
    check("mid_found", found, 1);
    rst_n = 0;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_mem_addr", mem_addr_a, 0);
    check("mid_rst_mem_done", mem_done_a, 1);
    tick();
    check("mid_rst_hold_valid", valid_a, 0);
    rst_n = 1;
    tick();
    start_a = 1;
    tick();
    start_a = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (valid_a) found = 1; else tick();
    end
    check("refetch_valid", found, 1);
    check("refetch_first", data_out_a, 8'h01);
    wait_idle_a();

    // Address wrap from 0xFC (unaligned base bits ignored).
    base_a = 8'hFE; start_a = 1;
    tick();
    start_a = 0;
    wait_idle_a();

    // Random traffic: ready toggling, start pulses at any time, random bases.
    for (int i = 0; i < 800; i++) begin
      ready_a = ($urandom % 4) != 0;
      start_a = ($urandom % 6) == 0;
      base_a  = 8'($urandom);
      tick();
    end
    start_a = 0; ready_a = 1;
    wait_idle_a();

    // Instance b: 6-byte filter, two fetches at 0x00 and 0x04.
    base_b = 8'h00; start_b = 1;
    tick();
    start_b = 0;
    got.delete(); addrs.delete(); last_idx = -1; fin_seen = 0;
    for (int i = 0; i < 40 && !fin_seen; i++) begin
      if (busy_b && !valid_b && !done_b) addrs.push_back(mem_addr_b);
      if (valid_b && ready_b) begin
        if (last_b) last_idx = got.size();
        got.push_back(data_out_b);
      end
      if (done_b) fin_seen = 1; else tick();
    end
    check("b_done_seen", fin_seen, 1);
    check("b_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) check("b_byte", got[i], 8'(i + 1));
    check("b_last_idx", last_idx, 5);
    check("b_fetches", addrs.size(), 2);
    if (addrs.size() == 2) begin
      check("b_addr0", addrs[0], 8'h00);
      check("b_addr1", addrs[1], 8'h04);
    end
    tick();

    // Instance c: 4-bit addresses wrap 0xC -> 0x0; start while busy ignored.
    base_c = 4'hC; start_c = 1;
    tick();
    start_c = 0;
    got.delete(); addrs.delete(); last_idx = -1; fin_seen = 0;
    for (int i = 0; i < 40 && !fin_seen; i++) begin
      start_c = (i == 3);
      if (busy_c && !valid_c && !done_c) addrs.push_back(8'(mem_addr_c));
      if (valid_c && ready_c) begin
        if (last_c) last_idx = got.size();
        got.push_back(data_out_c);
      end
      if (done_c) fin_seen = 1; else tick();
    end
    start_c = 0;
    check("c_done_seen", fin_seen, 1);
    check("c_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("c_byte", got[i], exp_c[i]);
    check("c_last_idx", last_idx, 7);
    check("c_fetches", addrs.size(), 2);
    if (addrs.size() == 2) begin
      check("c_addr0", addrs[0], 8'h0C);
      check("c_addr1", addrs[1], 8'h00);
    end
    repeat (3) begin
      tick();
      check("c_no_requeue", busy_c, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
